// File: rtl/enc_sequencer_pkg.sv
// Shared state/phase encoding and default sizing for the image-cipher sequencer.
package enc_seq_pkg;

  localparam int KEY_W_DEF  = 64;
  localparam int NPIX_DEF   = 65536;
  localparam int ADDR_W_DEF = 16;
  localparam int WARMUP_DEF = 256;

  // The state value doubles as the externally visible phase code.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_WARM  = 3'd2,
    ST_SBOX  = 3'd3,
    ST_SUBST = 3'd4,
    ST_DIFF  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/enc_sequencer_if.sv
// Datapath-side bus of the sequencer: chaotic map, S-box builder and pixel RAM.
interface enc_seq_if
  import enc_seq_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              map_load;
  logic [KEY_W-1:0]  map_seed;
  logic              map_step;
  logic              map_valid;
  logic              sbox_start;
  logic              done_sbox;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rd;
  logic              pix_rvalid;
  logic              pix_wr;

  modport master (
    output map_load, map_seed, map_step, sbox_start, pix_addr, pix_rd, pix_wr,
    input  map_valid, done_sbox, pix_rvalid
  );

  modport slave (
    input  map_load, map_seed, map_step, sbox_start, pix_addr, pix_rd, pix_wr,
    output map_valid, done_sbox, pix_rvalid
  );

endinterface

// File: rtl/enc_sequencer_pix_walker.sv
// Pixel address walker: read, wait for data, write back, advance; one pass over 0..NPIX-1.
module pix_walker
  import enc_seq_pkg::*;
#(
  parameter int NPIX   = NPIX_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              rvalid,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              at_last;

  assign at_last = (addr_q == LAST_ADDR);

  always_comb begin
    addr_d = addr_q;
    rd_d   = rd_q;
    wr_d   = 1'b0;
    if (go) begin
      addr_d = '0;
      rd_d   = 1'b1;
    end else if (wr_q) begin
      // Write-back cycle: advance, or wrap to 0 and stop after the final pixel.
      addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
      rd_d   = !at_last;
    end else if (rd_q && rvalid) begin
      rd_d = 1'b0;
      wr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  assign addr = addr_q;
  assign rd   = rd_q;
  assign wr   = wr_q;
  assign last = wr_q && at_last;

endmodule

// File: rtl/enc_sequencer.sv
// Cipher sequencer: seed and warm up the chaotic map, build the S-box, then walk the pixels.
// Define DIFFUSION_EN to follow the substitution pass with a diffusion pass.
//
// state | meaning
// IDLE  | waiting for start
// SEED  | map_load pulse with captured key
// WARM  | stepping the map, discarding WARMUP results
// SBOX  | sbox_start pulse, then wait for done_sbox
// SUBST | substitution read/write pass over all pixels
// DIFF  | diffusion read/write pass (DIFFUSION_EN only)
// DONE  | one-cycle done pulse
module enc_sequencer
  import enc_seq_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int NPIX   = NPIX_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  enc_seq_if.master        bus,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done
);

  localparam int                WCNT_W    = $clog2(WARMUP + 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [KEY_W-1:0]  map_seed_q, map_seed_d;
  logic              map_load_q, map_load_d;
  logic              map_step_q, map_step_d;
  logic              sbox_start_q, sbox_start_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              walk_go;
  logic              walk_last;
  logic [ADDR_W-1:0] walk_addr;
  logic              walk_rd;
  logic              walk_wr;

  pix_walker #(.NPIX(NPIX), .ADDR_W(ADDR_W)) u_walker (
    .clk    (clk),
    .rst    (rst),
    .go     (walk_go),
    .rvalid (bus.pix_rvalid),
    .addr   (walk_addr),
    .rd     (walk_rd),
    .wr     (walk_wr),
    .last   (walk_last)
  );

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    map_seed_d   = map_seed_q;
    map_load_d   = 1'b0;
    map_step_d   = 1'b0;
    sbox_start_d = 1'b0;
    done_d       = 1'b0;
    walk_go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          map_seed_d = key;
          warm_cnt_d = '0;
          map_load_d = 1'b1;
          state_d    = ST_SEED;
        end
      end
      ST_SEED: begin
        map_step_d = 1'b1;
        state_d    = ST_WARM;
      end
      ST_WARM: begin
        map_step_d = 1'b1;
        if (bus.map_valid) begin
          warm_cnt_d = warm_cnt_q + WCNT_W'(1);
          if (warm_cnt_q == WARM_LAST) begin
            map_step_d   = 1'b0;
            sbox_start_d = 1'b1;
            state_d      = ST_SBOX;
          end
        end
      end
      ST_SBOX: begin
        // A done_sbox level left over from a previous build is ignored on the entry cycle.
        if (!sbox_start_q && bus.done_sbox) begin
          walk_go = 1'b1;
          state_d = ST_SUBST;
        end
      end
      ST_SUBST: begin
        if (walk_last) begin
`ifdef DIFFUSION_EN
          walk_go = 1'b1;
          state_d = ST_DIFF;
`else
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end
      end
`ifdef DIFFUSION_EN
      ST_DIFF: begin
        if (walk_last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      warm_cnt_q   <= '0;
      map_seed_q   <= '0;
      map_load_q   <= 1'b0;
      map_step_q   <= 1'b0;
      sbox_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      map_seed_q   <= map_seed_d;
      map_load_q   <= map_load_d;
      map_step_q   <= map_step_d;
      sbox_start_q <= sbox_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.map_load   = map_load_q;
  assign bus.map_seed   = map_seed_q;
  assign bus.map_step   = map_step_q;
  assign bus.sbox_start = sbox_start_q;
  assign bus.pix_addr   = walk_addr;
  assign bus.pix_rd     = walk_rd;
  assign bus.pix_wr     = walk_wr;
  assign phase          = state_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_enc_sequencer.sv
// Randomized self-checking bench for enc_sequencer (NPIX=8, WARMUP=4, 1-cycle RAM latency).
module tb_enc_sequencer;

  localparam int KEY_W  = 64;
  localparam int NPIX   = 8;
  localparam int ADDR_W = 3;
  localparam int WARMUP = 4;
`ifdef DIFFUSION_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key = '0;
  logic [2:0]       phase;
  logic             busy;
  logic             done;

  logic done_sbox = 1'b0;
  logic map_valid_rsp = 1'b0, map_valid_inj = 1'b0;
  logic rvalid_rsp = 1'b0, rvalid_inj = 1'b0;

  int errors = 0;
  int checks = 0;

  int n_load = 0, n_sbox = 0, n_done = 0, n_valid_acc = 0, n_overlap = 0;
  logic [ADDR_W-1:0] wr_log[$];
  logic [2:0]        phase_log[$];

  enc_seq_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

  assign bus.map_valid  = map_valid_rsp | map_valid_inj;
  assign bus.pix_rvalid = rvalid_rsp | rvalid_inj;
  assign bus.done_sbox  = done_sbox;

  enc_sequencer #(.KEY_W(KEY_W), .NPIX(NPIX), .ADDR_W(ADDR_W), .WARMUP(WARMUP)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .bus   (bus),
    .phase (phase),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Chaotic map model: answers each map_step request 2 cycles later.
  initial begin
    int cd = 0;
    forever begin
      tick();
      map_valid_rsp = 1'b0;
      if (rst || !bus.map_step) cd = 0;
      else if (cd == 0) cd = 2;
      else begin
        cd--;
        if (cd == 0) map_valid_rsp = 1'b1;
      end
    end
  end

  // Pixel RAM model: read data valid one cycle after the request is seen.
  initial begin
    bit pend = 1'b0;
    forever begin
      tick();
      rvalid_rsp = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        rvalid_rsp = 1'b1;
        pend = 1'b0;
      end else if (bus.pix_rd) pend = 1'b1;
    end
  end

  // Observer: tallies strobes and records writes and phase changes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.map_load) n_load++;
        if (bus.sbox_start) n_sbox++;
        if (done) n_done++;
        if (bus.map_valid && phase == 3'd2) n_valid_acc++;
        if (bus.pix_rd && bus.pix_wr) n_overlap++;
        if (bus.pix_wr) wr_log.push_back(bus.pix_addr);
        if (phase_log.size() == 0 || phase_log[$] != phase) phase_log.push_back(phase);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({phase, busy, done, bus.map_load, bus.map_step, bus.sbox_start, bus.pix_rd, bus.pix_wr,
         bus.pix_addr} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got phase=%0d busy=%b done=%b load=%b step=%b sbox=%b rd=%b wr=%b addr=%0d, want all 0",
               phase, busy, done, bus.map_load, bus.map_step, bus.sbox_start, bus.pix_rd, bus.pix_wr, bus.pix_addr);
    end
    checks++;
    if (bus.map_seed !== 64'd0) begin
      errors++;
      $display("FAIL reset_seed: got %h want 0", bus.map_seed);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got phase=%0d busy=%b want 0 0", phase, busy);
    end
  endtask

  task automatic test_seed_warm(input logic [KEY_W-1:0] k, input bit poke);
    int base_load = n_load;
    int base_acc  = n_valid_acc;
    int cyc = 0;
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = ~k;
    checks++;
    if (phase !== 3'd1 || bus.map_load !== 1'b1) begin
      errors++;
      $display("FAIL seed_cycle: got phase=%0d load=%b want 1 1", phase, bus.map_load);
    end
    checks++;
    if (bus.map_seed !== k) begin
      errors++;
      $display("FAIL seed_value: got %h want %h", bus.map_seed, k);
    end
    tick();
    checks++;
    if (phase !== 3'd2 || bus.map_load !== 1'b0 || bus.map_step !== 1'b1) begin
      errors++;
      $display("FAIL warm_entry: got phase=%0d load=%b step=%b want 2 0 1", phase, bus.map_load, bus.map_step);
    end
    while (bus.sbox_start !== 1'b1 && cyc < 200) begin
      if (poke && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        key   = {$urandom(), $urandom()};
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 200) begin
      checks++;
      errors++;
      $display("FAIL warm_timeout: sbox_start not seen within %0d cycles", cyc);
    end
    checks++;
    if (phase !== 3'd3 || bus.map_step !== 1'b0) begin
      errors++;
      $display("FAIL sbox_entry: got phase=%0d step=%b want 3 0", phase, bus.map_step);
    end
    checks++;
    if (n_valid_acc - base_acc !== WARMUP) begin
      errors++;
      $display("FAIL warm_count: got %0d map_valid accepted want %0d", n_valid_acc - base_acc, WARMUP);
    end
    checks++;
    if (n_load - base_load !== 1 || bus.map_seed !== k) begin
      errors++;
      $display("FAIL seed_kept: got loads=%0d seed=%h want 1 %h", n_load - base_load, bus.map_seed, k);
    end
  endtask

  task automatic test_sbox_wait(input int nwait, input bit poke);
    int base_sbox = n_sbox;
    int base_load = n_load;
    int bad = 0;
    done_sbox = 1'b1;
    tick();
    done_sbox = 1'b0;
    checks++;
    if (phase !== 3'd3 || bus.pix_rd !== 1'b0 || bus.sbox_start !== 1'b0) begin
      errors++;
      $display("FAIL sbox_entry_done: got phase=%0d rd=%b sbox=%b want 3 0 0", phase, bus.pix_rd, bus.sbox_start);
    end
    for (int i = 0; i < nwait; i++) begin
      map_valid_inj = 1'($urandom_range(0, 1));
      rvalid_inj    = 1'($urandom_range(0, 1));
      if (poke) start = 1'($urandom_range(0, 1));
      tick();
      if (phase !== 3'd3 || bus.pix_rd !== 1'b0 || bus.pix_wr !== 1'b0 || bus.sbox_start !== 1'b0) bad++;
    end
    map_valid_inj = 1'b0;
    rvalid_inj    = 1'b0;
    start         = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL sbox_hold: got %0d bad cycles out of %0d want 0", bad, nwait);
    end
    done_sbox = 1'b1;
    tick();
    done_sbox = 1'b0;
    checks++;
    if (phase !== 3'd4 || bus.pix_addr !== 3'd0 || bus.pix_rd !== 1'b1 || bus.pix_wr !== 1'b0) begin
      errors++;
      $display("FAIL subst_entry: got phase=%0d addr=%0d rd=%b wr=%b want 4 0 1 0",
               phase, bus.pix_addr, bus.pix_rd, bus.pix_wr);
    end
    checks++;
    if (n_sbox - base_sbox !== 1 || n_load !== base_load) begin
      errors++;
      $display("FAIL sbox_pulses: got sbox=%0d loads=%0d want 1 0", n_sbox - base_sbox, n_load - base_load);
    end
  endtask

  task automatic test_subst_pass;
    int base_wr   = wr_log.size();
    int base_ph   = phase_log.size();
    int base_done = n_done;
    int base_ov   = n_overlap;
    int cyc = 0;
    int first_bad = -1;
    logic [ADDR_W-1:0] exp_wr[$];
    logic [2:0]        exp_ph[$];
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < NPIX; a++) exp_wr.push_back(ADDR_W'(a));
      exp_ph.push_back(3'(4 + p));
    end
    exp_ph.push_back(3'd6);
    exp_ph.push_back(3'd0);
    while (done !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== PASSES * NPIX * 3) begin
      errors++;
      $display("FAIL pass_cycles: got %0d cycles to done want %0d", cyc, PASSES * NPIX * 3);
    end
    checks++;
    if (phase !== 3'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got phase=%0d busy=%b want 6 0", phase, busy);
    end
    tick();
    checks++;
    if (phase !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got phase=%0d done=%b busy=%b want 0 0 0", phase, done, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wr_log.size() - base_wr !== exp_wr.size()) begin
      errors++;
      $display("FAIL wr_count: got %0d writes want %0d", wr_log.size() - base_wr, exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && base_wr + i < wr_log.size(); i++)
      if (first_bad < 0 && wr_log[base_wr + i] !== exp_wr[i]) first_bad = i;
    checks++;
    if (first_bad !== -1) begin
      errors++;
      $display("FAIL wr_order: write %0d got addr %0d want %0d",
               first_bad, wr_log[base_wr + first_bad], exp_wr[first_bad]);
    end
    checks++;
    if (n_overlap !== base_ov) begin
      errors++;
      $display("FAIL rd_wr_overlap: got %0d overlapping cycles want 0", n_overlap - base_ov);
    end
    checks++;
    if (n_done - base_done !== 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d want 1", n_done - base_done);
    end
    first_bad = -1;
    if (phase_log.size() - base_ph != exp_ph.size()) first_bad = 99;
    else
      for (int i = 0; i < exp_ph.size(); i++)
        if (first_bad < 0 && phase_log[base_ph + i] !== exp_ph[i]) first_bad = i;
    checks++;
    if (first_bad !== -1) begin
      errors++;
      $display("FAIL phase_seq: got %0d phase entries (first bad %0d) want %0d entries ending in 6,0",
               phase_log.size() - base_ph, first_bad, exp_ph.size());
    end
  endtask

  task automatic test_rst_mid;
    int base_done;
    int cyc = 0;
    test_seed_warm({$urandom(), $urandom()}, 1'b0);
    test_sbox_wait(int'($urandom_range(1, 5)), 1'b0);
    base_done = n_done;
    while (!(phase === 3'd4 && bus.pix_addr === 3'd3) && cyc < 100) begin
      tick();
      cyc++;
    end
    if (cyc >= 100) begin
      checks++;
      errors++;
      $display("FAIL rst_wait: pix_addr 3 not reached within %0d cycles", cyc);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({phase, busy, done, bus.map_load, bus.map_step, bus.sbox_start, bus.pix_rd, bus.pix_wr,
         bus.pix_addr} !== 13'd0 || bus.map_seed !== 64'd0) begin
      errors++;
      $display("FAIL rst_abort: got phase=%0d busy=%b done=%b rd=%b wr=%b addr=%0d seed=%h want all 0",
               phase, busy, done, bus.pix_rd, bus.pix_wr, bus.pix_addr, bus.map_seed);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0 || n_done !== base_done) begin
      errors++;
      $display("FAIL rst_quiet: got phase=%0d busy=%b extra_done=%0d want 0 0 0",
               phase, busy, n_done - base_done);
    end
    test_seed_warm({$urandom(), $urandom()}, 1'b0);
    test_sbox_wait(int'($urandom_range(0, 4)), 1'b0);
    test_subst_pass();
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      test_seed_warm({$urandom(), $urandom()}, 1'b1);
      test_sbox_wait(int'($urandom_range(0, 10)), 1'b1);
      test_subst_pass();
    end
  endtask

  initial begin
    test_reset();
    test_seed_warm(64'h0123_4567_89AB_CDEF, 1'b0);
    test_sbox_wait(50, 1'b0);
    test_subst_pass();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
